branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor feeding the fetch-stage PC register of the 16-bit pipelined CPU. It supplies the predicted next PC (`pre_pc`) for the instruction being fetched, and resolves branches arriving from the EX stage. On a misprediction it raises `error` with the corrected `new_pc`, which the PC register takes in preference to `pre_pc`. Prediction uses a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, trained on every resolved branch.

## Interface
Parameters:
- `IDX_BITS`, default 4: BTB index width; the table has 2^IDX_BITS entries.
- `TAG_BITS`, default 16-IDX_BITS: stored tag width, taken as `pc[15:IDX_BITS]`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_pc`  in  16  PC currently being fetched.
- `pre_pc`  out  16  predicted next PC (combinational).
- `pred_taken`  out  1  prediction for `fetch_pc`; carried down the pipeline.
- `ex_valid`  in  1  EX-stage instruction is valid (not a bubble or flushed).
- `ex_pc`  in  16  PC of the EX instruction.
- `ex_is_branch`  in  1  EX instruction is a branch or jump.
- `ex_taken`  in  1  actual branch outcome.
- `ex_target`  in  16  actual branch target.
- `ex_pred_taken`  in  1  `pred_taken` value carried with this instruction.
- `ex_pred_pc`  in  16  `pre_pc` value carried with this instruction.
- `error`  out  1  misprediction detected (combinational).
- `new_pc`  out  16  corrected PC; valid when `error`=1.
- `bp_branches`, `bp_mispredicts`  out  16 each  statistics counters (only with `BP_STATS_EN`).

## Operation
- Entry fields: `valid`, `tag[TAG_BITS]`, `target[16]`, `cnt[2]`. Index is `pc[IDX_BITS-1:0]`.
- Lookup: a hit is `valid` && tag match. `pred_taken` = hit && `cnt[1]`. `pre_pc` = `pred_taken` ? `target` : `fetch_pc`+1. PCs are word addresses; all arithmetic is mod 2^16, so 0xFFFF+1 = 0x0000.
- Resolution, active only when `ex_valid`=1:
  - Correct next PC: `ex_is_branch` && `ex_taken` ? `ex_target` : `ex_pc`+1.
  - `error`=1 when the correct next PC differs from `ex_pred_pc`. `new_pc` is the correct next PC.
  - When `ex_valid`=0: `error`=0 and `new_pc`=0.
- Training, registered on the rising edge when `ex_valid`=1:
  - Branch, hit: `cnt` increments on taken and decrements on not taken, saturating at 3 and 0. On taken, `target` is set to `ex_target`.
  - Branch, miss, taken: allocate the entry (overwriting any occupant) with `valid`=1, the new tag, `target`=`ex_target`, `cnt`=2.
  - Branch, miss, not taken: no change.
  - Non-branch that hits (alias): clear `valid`.
- Reset: every `valid`=0, `cnt`=1, `target`=0, tag=0, statistics counters=0. Outputs after reset: `pred_taken`=0, `pre_pc`=`fetch_pc`+1, `error`=0 while `ex_valid`=0.

## Timing
- Lookup and error detection are zero-latency combinational paths. The PC register samples them within the same cycle.
- A table update becomes visible to lookups on the cycle after the training edge.
- If lookup and update hit the same index in one cycle, the lookup returns the pre-update contents.
- Stalls do not gate the predictor; `fetch_pc` held constant yields a constant prediction. The EX stage must drop `ex_valid` for repeated or flushed instructions, so each branch trains exactly once.
- `rst` asserted mid-operation clears the table on that edge. Combinational outputs still follow their inputs during reset, so upstream flushes on reset.

## Configuration
- `BP_STATS_EN` defined: `bp_branches` increments on each valid resolved branch. `bp_mispredicts` increments on each cycle with `error`=1. Both saturate at 0xFFFF and are cleared by `rst`.
- `BP_STATS_EN` undefined: both ports and their counters are absent. Prediction behaviour is identical.

## Test plan
- After reset, `fetch_pc`=0x0010 -> `pre_pc`=0x0011, `pred_taken`=0. Also `fetch_pc`=0xFFFF -> `pre_pc`=0x0000.
- Resolve branch at `ex_pc`=0x0020, taken to 0x0040, with `ex_pred_pc`=0x0021 -> `error`=1, `new_pc`=0x0040. Next cycle, `fetch_pc`=0x0020 -> `pre_pc`=0x0040, `pred_taken`=1.
- Same branch resolved taken twice, then not taken once -> `cnt` goes 2→3→3→2 and the prediction stays taken. Two further not-taken resolutions -> `pre_pc`=0x0021.
- Non-branch at 0x0030 aliasing an entry with index 0 -> `valid` cleared. Predicted 0x0040 versus correct 0x0031 -> `error`=1, `new_pc`=0x0031.
- Same-cycle lookup and update on one index -> lookup shows the old entry; the new entry appears on the next cycle.
- With `BP_STATS_EN`, 0x10000 mispredicting branches -> `bp_mispredicts`=0xFFFF (saturated). Reset -> both counters read 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/EX-side signal bundle for branch_predictor.
// Statistics signals exist only when BP_STATS_EN is defined.
interface branch_predictor_if;
   logic [15:0] fetch_pc;
   logic [15:0] pre_pc;
   logic        pred_taken;
   logic        ex_valid;
   logic [15:0] ex_pc;
   logic        ex_is_branch;
   logic        ex_taken;
   logic [15:0] ex_target;
   logic        ex_pred_taken;
   logic [15:0] ex_pred_pc;
   logic        error;
   logic [15:0] new_pc;
`ifdef BP_STATS_EN
   logic [15:0] bp_branches;
   logic [15:0] bp_mispredicts;

   modport master (
      output fetch_pc, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
             ex_pred_taken, ex_pred_pc,
      input  pre_pc, pred_taken, error, new_pc, bp_branches, bp_mispredicts
   );
   modport slave (
      input  fetch_pc, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
             ex_pred_taken, ex_pred_pc,
      output pre_pc, pred_taken, error, new_pc, bp_branches, bp_mispredicts
   );
`else
   modport master (
      output fetch_pc, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
             ex_pred_taken, ex_pred_pc,
      input  pre_pc, pred_taken, error, new_pc
   );
   modport slave (
      input  fetch_pc, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
             ex_pred_taken, ex_pred_pc,
      output pre_pc, pred_taken, error, new_pc
   );
`endif
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor with 2-bit counters; combinational lookup/resolve, trained per EX branch.
// Optional saturating statistics counters enabled by defining BP_STATS_EN.
module branch_predictor #(
   parameter int IDX_BITS = 4,
   parameter int TAG_BITS = 16 - IDX_BITS
) (
   input  logic              clk,
   input  logic              rst,
   branch_predictor_if.slave bp
);
   localparam int NENT = 1 << IDX_BITS;

   typedef struct packed {
      logic                valid;
      logic [TAG_BITS-1:0] tag;
      logic [15:0]         target;
      logic [1:0]          cnt;
   } entry_t;

   entry_t tbl [NENT];

   logic [IDX_BITS-1:0] f_idx, e_idx;
   entry_t              f_ent, e_ent;
   logic                f_hit, e_hit;
   logic [15:0]         ex_next;

   assign f_idx = bp.fetch_pc[IDX_BITS-1:0];
   assign e_idx = bp.ex_pc[IDX_BITS-1:0];
   assign f_ent = tbl[f_idx];
   assign e_ent = tbl[e_idx];
   assign f_hit = f_ent.valid && (f_ent.tag == bp.fetch_pc[IDX_BITS +: TAG_BITS]);
   assign e_hit = e_ent.valid && (e_ent.tag == bp.ex_pc[IDX_BITS +: TAG_BITS]);

   // Lookup reads the table before this edge's update, so same-index training shows next cycle.
   assign bp.pred_taken = f_hit && f_ent.cnt[1];
   assign bp.pre_pc     = bp.pred_taken ? f_ent.target : bp.fetch_pc + 16'd1;

   assign ex_next   = (bp.ex_is_branch && bp.ex_taken) ? bp.ex_target : bp.ex_pc + 16'd1;
   assign bp.error  = bp.ex_valid && (ex_next != bp.ex_pred_pc);
   assign bp.new_pc = bp.ex_valid ? ex_next : 16'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NENT; i++)
            tbl[i] <= '{valid: 1'b0, tag: '0, target: 16'd0, cnt: 2'd1};
      end else if (bp.ex_valid) begin
         if (bp.ex_is_branch) begin
            if (e_hit) begin
               if (bp.ex_taken) begin
                  tbl[e_idx].target <= bp.ex_target;
                  if (e_ent.cnt != 2'd3) tbl[e_idx].cnt <= e_ent.cnt + 2'd1;
               end else if (e_ent.cnt != 2'd0) begin
                  tbl[e_idx].cnt <= e_ent.cnt - 2'd1;
               end
            end else if (bp.ex_taken) begin
               tbl[e_idx] <= '{valid: 1'b1, tag: bp.ex_pc[IDX_BITS +: TAG_BITS],
                               target: bp.ex_target, cnt: 2'd2};
            end
         end else if (e_hit) begin
            // A non-branch matching an entry means stale/aliased code: drop it.
            tbl[e_idx].valid <= 1'b0;
         end
      end
   end

`ifdef BP_STATS_EN
   logic [15:0] br_cnt, mp_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt <= 16'd0;
         mp_cnt <= 16'd0;
      end else begin
         if (bp.ex_valid && bp.ex_is_branch && br_cnt != 16'hFFFF) br_cnt <= br_cnt + 16'd1;
         if (bp.error && mp_cnt != 16'hFFFF) mp_cnt <= mp_cnt + 16'd1;
      end
   end

   assign bp.bp_branches    = br_cnt;
   assign bp.bp_mispredicts = mp_cnt;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vectors, literal expectations and a per-cycle reference model.
`timescale 1ns/1ps
module tb_branch_predictor;
   localparam int IDX = 4;
   localparam int NENT = 1 << IDX;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_predictor_if bp();
   branch_predictor #(.IDX_BITS(IDX)) dut (.clk(clk), .rst(rst), .bp(bp));

   int checks = 0;
   int failures = 0;

   // Reference model: per index, which full PC owns it, its target and confidence.
   int own [int];
   int tgt [int];
   int cnf [int];
   int m_br = 0;
   int m_mp = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every cycle, then advance the model with the inputs the DUT sees at the next edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            own.delete(); tgt.delete(); cnf.delete();
            m_br = 0; m_mp = 0;
         end else begin
            int fi, ei, fpc, epc, corr, ppc;
            bit fhit, ehit, ptk, err;
            fpc = int'(bp.fetch_pc); epc = int'(bp.ex_pc); ppc = int'(bp.ex_pred_pc);
            fi = fpc % NENT; ei = epc % NENT;
            fhit = own.exists(fi) && own[fi] == fpc;
            ehit = own.exists(ei) && own[ei] == epc;
            ptk = fhit && cnf[fi] >= 2;
            chk("m_pred_taken", {15'd0, bp.pred_taken}, {15'd0, ptk});
            chk("m_pre_pc", bp.pre_pc, ptk ? 16'(tgt[fi]) : 16'((fpc + 1) % 65536));
            corr = (bp.ex_is_branch && bp.ex_taken) ? int'(bp.ex_target) : (epc + 1) % 65536;
            err = bp.ex_valid && corr != ppc;
            chk("m_error", {15'd0, bp.error}, {15'd0, err});
            chk("m_new_pc", bp.new_pc, bp.ex_valid ? 16'(corr) : 16'd0);
`ifdef BP_STATS_EN
            chk("m_branches", bp.bp_branches, 16'(m_br));
            chk("m_mispredicts", bp.bp_mispredicts, 16'(m_mp));
            if (bp.ex_valid && bp.ex_is_branch && m_br < 65535) m_br++;
            if (err && m_mp < 65535) m_mp++;
`endif
            if (bp.ex_valid) begin
               if (bp.ex_is_branch) begin
                  if (ehit) begin
                     if (bp.ex_taken) begin
                        tgt[ei] = int'(bp.ex_target);
                        cnf[ei] = (cnf[ei] < 3) ? cnf[ei] + 1 : 3;
                     end else begin
                        cnf[ei] = (cnf[ei] > 0) ? cnf[ei] - 1 : 0;
                     end
                  end else if (bp.ex_taken) begin
                     own[ei] = epc; tgt[ei] = int'(bp.ex_target); cnf[ei] = 2;
                  end
               end else if (ehit) begin
                  own.delete(ei);
               end
            end
         end
      end
   end

   task automatic drive(input logic [15:0] fpc, input logic v, input logic [15:0] pc,
                        input logic br, input logic tk, input logic [15:0] t,
                        input logic [15:0] ppc);
      @(posedge clk); #1;
      bp.fetch_pc = fpc; bp.ex_valid = v; bp.ex_pc = pc; bp.ex_is_branch = br;
      bp.ex_taken = tk; bp.ex_target = t; bp.ex_pred_pc = ppc; bp.ex_pred_taken = 1'b0;
      #1;
   endtask

   task automatic idle(input logic [15:0] fpc);
      drive(fpc, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0);
   endtask

   initial begin
      bp.fetch_pc = 16'd0; bp.ex_valid = 1'b0; bp.ex_pc = 16'd0; bp.ex_is_branch = 1'b0;
      bp.ex_taken = 1'b0; bp.ex_target = 16'd0; bp.ex_pred_pc = 16'd0; bp.ex_pred_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      idle(16'h0010);
      chk("rst_pre_pc", bp.pre_pc, 16'h0011);
      chk("rst_pred_taken", {15'd0, bp.pred_taken}, 16'd0);
      chk("rst_error", {15'd0, bp.error}, 16'd0);
      chk("rst_new_pc", bp.new_pc, 16'd0);
      idle(16'hFFFF);
      chk("wrap_pre_pc", bp.pre_pc, 16'h0000);

      // Allocate on first taken resolution; lookup on same index still sees the old entry.
      drive(16'h0020, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h0040, 16'h0021);
      chk("alloc_error", {15'd0, bp.error}, 16'd1);
      chk("alloc_new_pc", bp.new_pc, 16'h0040);
      chk("same_cyc_pre_pc", bp.pre_pc, 16'h0021);
      idle(16'h0020);
      chk("after_alloc_pre_pc", bp.pre_pc, 16'h0040);
      chk("after_alloc_taken", {15'd0, bp.pred_taken}, 16'd1);

      drive(16'h0020, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h0040, 16'h0040);
      chk("taken2_error", {15'd0, bp.error}, 16'd0);
      drive(16'h0020, 1'b1, 16'h0020, 1'b1, 1'b1, 16'h0040, 16'h0040);
      drive(16'h0020, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0040, 16'h0040);
      chk("nt1_error", {15'd0, bp.error}, 16'd1);
      chk("nt1_new_pc", bp.new_pc, 16'h0021);
      idle(16'h0020);
      chk("cnt2_pre_pc", bp.pre_pc, 16'h0040);
      drive(16'h0020, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0040, 16'h0040);
      drive(16'h0020, 1'b1, 16'h0020, 1'b1, 1'b0, 16'h0040, 16'h0021);
      chk("cnt1_pre_pc", bp.pre_pc, 16'h0021);
      idle(16'h0020);
      chk("cnt0_pre_pc", bp.pre_pc, 16'h0021);

      // Entry at 0x0030 overwrites index 0, then a non-branch there invalidates it.
      drive(16'h0030, 1'b1, 16'h0030, 1'b1, 1'b1, 16'h0040, 16'h0031);
      idle(16'h0030);
      chk("alias_pre_pc", bp.pre_pc, 16'h0040);
      drive(16'h0020, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h0000, 16'h0040);
      chk("alias_error", {15'd0, bp.error}, 16'd1);
      chk("alias_new_pc", bp.new_pc, 16'h0031);
      chk("evicted_pre_pc", bp.pre_pc, 16'h0021);
      idle(16'h0030);
      chk("cleared_pre_pc", bp.pre_pc, 16'h0031);
      chk("cleared_taken", {15'd0, bp.pred_taken}, 16'd0);

      drive(16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h1234, 16'h0000);
      chk("wrap_nt_error", {15'd0, bp.error}, 16'd0);
      drive(16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h1234, 16'h0000);
      idle(16'hFFFF);
      chk("wrap_alloc_pre_pc", bp.pre_pc, 16'h1234);

      for (int i = 0; i < 300; i++) begin
         logic [15:0] p;
         p = 16'(16'h0100 + 16'($urandom_range(0, 5)) * 16'h0008);
         drive(16'(16'h0100 + 16'($urandom_range(0, 5)) * 16'h0008), 1'($urandom_range(0, 1)),
               p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               16'(16'h0200 + 16'($urandom_range(0, 3))),
               $urandom_range(0, 1) ? 16'(p + 16'd1) : 16'(16'h0200 + 16'($urandom_range(0, 3))));
      end

      @(posedge clk); #1 rst = 1'b1;
      bp.ex_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      idle(16'hFFFF);
      chk("midrst_pre_pc", bp.pre_pc, 16'h0000);
      chk("midrst_taken", {15'd0, bp.pred_taken}, 16'd0);

`ifdef BP_STATS_EN
      drive(16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (65536) @(posedge clk);
      #2;
      chk("stat_mp_sat", bp.bp_mispredicts, 16'hFFFF);
      chk("stat_br_none", bp.bp_branches, 16'h0000);
      @(posedge clk); #1 rst = 1'b1;
      bp.ex_valid = 1'b0;
      @(posedge clk); #2;
      chk("stat_rst_mp", bp.bp_mispredicts, 16'h0000);
      chk("stat_rst_br", bp.bp_branches, 16'h0000);
      rst = 1'b0;
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
